// File: rtl/img_pixel_fetch.sv
// Display-side pixel fetch: places the loader stream in a fixed raster window,
// fills border/underflow pixels, applies a pixel mode and delay-matches sync.
module img_pixel_fetch #(
    parameter int         IMG_X0 = 64,
    parameter int         IMG_Y0 = 32,
    parameter int         IMG_W  = 256,
    parameter int         IMG_H  = 256,
    parameter int         CNT_W  = 12,
    parameter logic [7:0] BORDER = 8'h00,
    parameter logic [7:0] UFILL  = 8'hFF
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             i_de,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic [CNT_W-1:0] i_cnt_hor,
    input  logic [CNT_W-1:0] i_cnt_ver,
    input  logic             i_valid,
    input  logic [7:0]       i_data,
    output logic             o_next,
    output logic             o_frame_restart,
    input  logic [1:0]       i_mode,
    input  logic [7:0]       i_thresh,
    output logic             o_de,
    output logic             o_hs,
    output logic             o_vs,
    output logic [7:0]       o_data,
    output logic             o_underflow,
    output logic [7:0]       o_frame_cnt
);
    localparam int CW1 = CNT_W + 1;
    localparam logic [CW1-1:0] X_LO = CW1'(IMG_X0);
    localparam logic [CW1-1:0] X_HI = CW1'(IMG_X0 + IMG_W);
    localparam logic [CW1-1:0] Y_LO = CW1'(IMG_Y0);
    localparam logic [CW1-1:0] Y_HI = CW1'(IMG_Y0 + IMG_H);
    // One bit wider than 16 so a full 65536-pixel image can still hit the limit.
    localparam logic [16:0]    NPIX = 17'(IMG_W * IMG_H);

    logic        vs_q, vs_d;
    logic        armed_q, armed_d;
    logic [16:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        restart_q, restart_d;
    logic        underflow_q, underflow_d;
    logic [7:0]  p1_q, p1_d;
    logic        w1_q, w1_d;
    logic        de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [7:0]  data2_q, data2_d;
    logic        de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;

    logic           vs_rise, in_win, pop;
    logic [CW1-1:0] hor_w, ver_w;

    always_comb begin
        hor_w   = {1'b0, i_cnt_hor};
        ver_w   = {1'b0, i_cnt_ver};
        vs_rise = i_vs & ~vs_q;
        in_win  = i_de & armed_q & ~vs_rise
                & (hor_w >= X_LO) & (hor_w < X_HI)
                & (ver_w >= Y_LO) & (ver_w < Y_HI);
        pop     = in_win & i_valid & (pix_cnt_q < NPIX);

        vs_d        = i_vs;
        armed_d     = armed_q | vs_rise;
        restart_d   = vs_rise;
        frame_cnt_d = frame_cnt_q + {7'd0, vs_rise};
        pix_cnt_d   = pix_cnt_q;
        if (vs_rise)
            pix_cnt_d = '0;
        else if (pop)
            pix_cnt_d = pix_cnt_q + 17'd1;

        // A window cycle without a pop (empty head or image exhausted) is an underflow.
        underflow_d = underflow_q | (in_win & ~pop);
        p1_d        = BORDER;
        if (in_win)
            p1_d = pop ? i_data : UFILL;
        w1_d  = in_win;
        de1_d = i_de;
        hs1_d = i_hs;
        vs1_d = i_vs;

        data2_d = BORDER;
        if (w1_q) begin
            case (i_mode)
                2'd0:    data2_d = p1_q;
                2'd1:    data2_d = ~p1_q;
                2'd2:    data2_d = (p1_q >= i_thresh) ? 8'hFF : 8'h00;
                default: data2_d = BORDER;
            endcase
        end
        de2_d = de1_q;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
    end

    // Keep the loader untouched while reset is held, even before the flops clear.
    assign o_next          = pop & rst_n;
    assign o_frame_restart = restart_q;
    assign o_underflow     = underflow_q;
    assign o_frame_cnt     = frame_cnt_q;
    assign o_data          = data2_q;
    assign o_de            = de2_q;
    assign o_hs            = hs2_q;
    assign o_vs            = vs2_q;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            vs_q        <= 1'b1;
            armed_q     <= 1'b0;
            pix_cnt_q   <= '0;
            frame_cnt_q <= '0;
            restart_q   <= 1'b0;
            underflow_q <= 1'b0;
            p1_q        <= 8'h00;
            w1_q        <= 1'b0;
            de1_q       <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            data2_q     <= 8'h00;
            de2_q       <= 1'b0;
            hs2_q       <= 1'b0;
            vs2_q       <= 1'b0;
        end else begin
            vs_q        <= vs_d;
            armed_q     <= armed_d;
            pix_cnt_q   <= pix_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            restart_q   <= restart_d;
            underflow_q <= underflow_d;
            p1_q        <= p1_d;
            w1_q        <= w1_d;
            de1_q       <= de1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            data2_q     <= data2_d;
            de2_q       <= de2_d;
            hs2_q       <= hs2_d;
            vs2_q       <= vs2_d;
        end
    end
endmodule

// File: tb/tb_img_pixel_fetch.sv
// Directed bench for img_pixel_fetch on a reduced raster: 8x4 window at (3,2)
// inside a 12x8 active area, loader modelled as an incrementing byte source.
module tb_img_pixel_fetch;
    localparam int         CNT_W  = 4;
    localparam int         X0     = 3;
    localparam int         Y0     = 2;
    localparam int         W      = 8;
    localparam int         H      = 4;
    localparam int         H_ACT  = 12;
    localparam int         V_ACT  = 8;
    localparam logic [7:0] BORDER = 8'h5A;
    localparam logic [7:0] UFILL  = 8'hFF;

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic             i_de, i_hs, i_vs, i_valid;
    logic [CNT_W-1:0] i_cnt_hor, i_cnt_ver;
    logic [7:0]       i_data, i_thresh;
    logic [1:0]       i_mode;
    logic             o_next, o_frame_restart, o_de, o_hs, o_vs, o_underflow;
    logic [7:0]       o_data, o_frame_cnt;

    img_pixel_fetch #(
        .IMG_X0(X0), .IMG_Y0(Y0), .IMG_W(W), .IMG_H(H), .CNT_W(CNT_W),
        .BORDER(BORDER), .UFILL(UFILL)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
        .i_cnt_hor(i_cnt_hor), .i_cnt_ver(i_cnt_ver),
        .i_valid(i_valid), .i_data(i_data), .o_next(o_next),
        .o_frame_restart(o_frame_restart), .i_mode(i_mode), .i_thresh(i_thresh),
        .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs), .o_data(o_data),
        .o_underflow(o_underflow), .o_frame_cnt(o_frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         pop_cnt, restart_cnt, sync_err;
    int         ld_ptr;
    logic [7:0] ld_base;
    logic       drop_en;
    logic       pop_map [0:V_ACT-1][0:H_ACT-1];
    logic [7:0] out_map [0:V_ACT-1][0:H_ACT-1];
    logic       h_de [0:1];
    logic       h_hs [0:1];
    logic       h_vs [0:1];
    int         h_x [0:1];
    int         h_y [0:1];

    // One raster cycle: drive at the falling edge, sample 1ns later, advance the loader.
    task automatic cyc(input logic de, input logic hs, input logic vs,
                       input int x, input int y, input logic vld);
        logic nxt, rs;
        i_de = de; i_hs = hs; i_vs = vs;
        i_cnt_hor = CNT_W'(x); i_cnt_ver = CNT_W'(y);
        i_valid = vld; i_data = ld_base + 8'(ld_ptr);
        #1;
        if (o_next) begin
            pop_cnt++;
            if (de) pop_map[y][x] = 1'b1;
        end
        if (o_frame_restart) restart_cnt++;
        if (o_de !== h_de[1] || o_hs !== h_hs[1] || o_vs !== h_vs[1]) sync_err++;
        if (h_de[1] === 1'b1) out_map[h_y[1]][h_x[1]] = o_data;
        h_de[1] = h_de[0]; h_hs[1] = h_hs[0]; h_vs[1] = h_vs[0];
        h_x[1] = h_x[0]; h_y[1] = h_y[0];
        h_de[0] = de; h_hs[0] = hs; h_vs[0] = vs; h_x[0] = x; h_y[0] = y;
        nxt = o_next; rs = o_frame_restart;
        @(negedge sys_clk);
        if (rs) ld_ptr = 0;
        else if (nxt) ld_ptr++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    // Full frame; rst_row >= 0 pulses rst_n low for 2 cycles at column 0 of that row.
    task automatic run_frame(input int rst_row);
        logic vld;
        pop_cnt = 0; restart_cnt = 0; sync_err = 0;
        for (int y = 0; y < V_ACT; y++)
            for (int x = 0; x < H_ACT; x++) begin
                pop_map[y][x] = 1'b0;
                out_map[y][x] = 8'hEE;
            end
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        idle(2);
        for (int y = 0; y < V_ACT; y++) begin
            for (int x = 0; x < H_ACT; x++) begin
                rst_n = !(y == rst_row && x < 2);
                vld = !(drop_en && y == 3 && x >= 5 && x <= 7);
                cyc(1'b1, 1'b0, 1'b0, x, y, vld);
            end
            rst_n = 1'b1;
            cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
            cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
        end
        idle(3);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        vec_cnt++; if (o_next !== 1'b0) begin err_cnt++; $display("FAIL reset_next: got %b want 0", o_next); end
        vec_cnt++; if (o_frame_restart !== 1'b0) begin err_cnt++; $display("FAIL reset_restart: got %b want 0", o_frame_restart); end
        vec_cnt++; if ({o_de, o_hs, o_vs} !== 3'b000) begin err_cnt++; $display("FAIL reset_sync: got %b want 000", {o_de, o_hs, o_vs}); end
        vec_cnt++; if (o_data !== 8'h00) begin err_cnt++; $display("FAIL reset_data: got %h want 00", o_data); end
        vec_cnt++; if (o_underflow !== 1'b0) begin err_cnt++; $display("FAIL reset_underflow: got %b want 0", o_underflow); end
        vec_cnt++; if (o_frame_cnt !== 8'd0) begin err_cnt++; $display("FAIL reset_frame_cnt: got %0d want 0", o_frame_cnt); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic_frame;
        run_frame(-1);
        vec_cnt++; if (pop_cnt !== W*H) begin err_cnt++; $display("FAIL basic_pops: got %0d want %0d", pop_cnt, W*H); end
        vec_cnt++; if (out_map[2][3] !== 8'h00) begin err_cnt++; $display("FAIL basic_first_pix: got %h want 00", out_map[2][3]); end
        vec_cnt++; if (out_map[5][10] !== 8'h1F) begin err_cnt++; $display("FAIL basic_last_pix: got %h want 1f", out_map[5][10]); end
        vec_cnt++; if (out_map[3][4] !== 8'h09) begin err_cnt++; $display("FAIL basic_mid_pix: got %h want 09", out_map[3][4]); end
        vec_cnt++; if (out_map[0][0] !== BORDER) begin err_cnt++; $display("FAIL basic_border_tl: got %h want %h", out_map[0][0], BORDER); end
        vec_cnt++; if (out_map[6][5] !== BORDER) begin err_cnt++; $display("FAIL basic_border_below: got %h want %h", out_map[6][5], BORDER); end
        vec_cnt++; if (sync_err !== 0) begin err_cnt++; $display("FAIL basic_sync_delay: got %0d bad cycles want 0", sync_err); end
        vec_cnt++; if (o_frame_cnt !== 8'd1) begin err_cnt++; $display("FAIL basic_frame_cnt: got %0d want 1", o_frame_cnt); end
        vec_cnt++; if (restart_cnt !== 1) begin err_cnt++; $display("FAIL basic_restart: got %0d want 1", restart_cnt); end
    endtask

    task automatic test_window_edges;
        run_frame(-1);
        vec_cnt++; if (pop_map[2][2] !== 1'b0) begin err_cnt++; $display("FAIL edge_col_lo_out: got %b want 0", pop_map[2][2]); end
        vec_cnt++; if (pop_map[2][3] !== 1'b1) begin err_cnt++; $display("FAIL edge_col_lo_in: got %b want 1", pop_map[2][3]); end
        vec_cnt++; if (pop_map[2][10] !== 1'b1) begin err_cnt++; $display("FAIL edge_col_hi_in: got %b want 1", pop_map[2][10]); end
        vec_cnt++; if (pop_map[2][11] !== 1'b0) begin err_cnt++; $display("FAIL edge_col_hi_out: got %b want 0", pop_map[2][11]); end
        vec_cnt++; if (pop_map[1][3] !== 1'b0) begin err_cnt++; $display("FAIL edge_row_lo_out: got %b want 0", pop_map[1][3]); end
        vec_cnt++; if (pop_map[5][3] !== 1'b1) begin err_cnt++; $display("FAIL edge_row_hi_in: got %b want 1", pop_map[5][3]); end
        vec_cnt++; if (pop_map[6][3] !== 1'b0) begin err_cnt++; $display("FAIL edge_row_hi_out: got %b want 0", pop_map[6][3]); end
        vec_cnt++; if (out_map[2][11] !== BORDER) begin err_cnt++; $display("FAIL edge_col_hi_pix: got %h want %h", out_map[2][11], BORDER); end
    endtask

    task automatic test_underflow;
        vec_cnt++; if (o_underflow !== 1'b0) begin err_cnt++; $display("FAIL uf_pre: got %b want 0", o_underflow); end
        drop_en = 1'b1;
        run_frame(-1);
        drop_en = 1'b0;
        vec_cnt++; if ({out_map[3][5], out_map[3][6], out_map[3][7]} !== {3{UFILL}}) begin err_cnt++; $display("FAIL uf_fill: got %h want ffffff", {out_map[3][5], out_map[3][6], out_map[3][7]}); end
        vec_cnt++; if ({pop_map[3][5], pop_map[3][6], pop_map[3][7]} !== 3'b000) begin err_cnt++; $display("FAIL uf_no_pop: got %b want 000", {pop_map[3][5], pop_map[3][6], pop_map[3][7]}); end
        vec_cnt++; if (pop_cnt !== W*H-3) begin err_cnt++; $display("FAIL uf_pops: got %0d want %0d", pop_cnt, W*H-3); end
        vec_cnt++; if (out_map[3][8] !== 8'h0A) begin err_cnt++; $display("FAIL uf_resume_pix: got %h want 0a", out_map[3][8]); end
        vec_cnt++; if (o_underflow !== 1'b1) begin err_cnt++; $display("FAIL uf_set: got %b want 1", o_underflow); end
        run_frame(-1);
        vec_cnt++; if (o_underflow !== 1'b1) begin err_cnt++; $display("FAIL uf_sticky: got %b want 1", o_underflow); end
        vec_cnt++; if (out_map[2][3] !== 8'h00) begin err_cnt++; $display("FAIL uf_next_frame_pix: got %h want 00", out_map[2][3]); end
    endtask

    task automatic test_modes;
        i_mode = 2'd1; ld_base = 8'h3C;
        run_frame(-1);
        vec_cnt++; if (out_map[2][3] !== 8'hC3) begin err_cnt++; $display("FAIL mode1_invert: got %h want c3", out_map[2][3]); end
        vec_cnt++; if (out_map[0][0] !== BORDER) begin err_cnt++; $display("FAIL mode1_border: got %h want %h", out_map[0][0], BORDER); end
        i_mode = 2'd2; i_thresh = 8'h80; ld_base = 8'h7F;
        run_frame(-1);
        vec_cnt++; if (out_map[2][3] !== 8'h00) begin err_cnt++; $display("FAIL mode2_below: got %h want 00", out_map[2][3]); end
        vec_cnt++; if (out_map[2][4] !== 8'hFF) begin err_cnt++; $display("FAIL mode2_equal: got %h want ff", out_map[2][4]); end
        i_mode = 2'd3; ld_base = 8'h00;
        run_frame(-1);
        vec_cnt++; if (out_map[2][3] !== BORDER || out_map[4][7] !== BORDER) begin err_cnt++; $display("FAIL mode3_border: got %h/%h want %h", out_map[2][3], out_map[4][7], BORDER); end
        vec_cnt++; if (pop_cnt !== W*H) begin err_cnt++; $display("FAIL mode3_pops: got %0d want %0d", pop_cnt, W*H); end
        i_mode = 2'd0;
    endtask

    task automatic test_mid_reset;
        run_frame(4);
        vec_cnt++; if (pop_cnt !== 2*W) begin err_cnt++; $display("FAIL midrst_pops: got %0d want %0d", pop_cnt, 2*W); end
        vec_cnt++; if (pop_map[4][3] !== 1'b0 || pop_map[5][10] !== 1'b0) begin err_cnt++; $display("FAIL midrst_no_pop: got %b%b want 00", pop_map[4][3], pop_map[5][10]); end
        vec_cnt++; if (out_map[5][5] !== BORDER) begin err_cnt++; $display("FAIL midrst_pix: got %h want %h", out_map[5][5], BORDER); end
        vec_cnt++; if (o_frame_cnt !== 8'd0 || o_underflow !== 1'b0) begin err_cnt++; $display("FAIL midrst_clear: got cnt %0d uf %b want 0 0", o_frame_cnt, o_underflow); end
        run_frame(-1);
        vec_cnt++; if (restart_cnt !== 1) begin err_cnt++; $display("FAIL midrst_restart: got %0d want 1", restart_cnt); end
        vec_cnt++; if (out_map[2][3] !== 8'h00 || out_map[2][4] !== 8'h01) begin err_cnt++; $display("FAIL midrst_realign: got %h %h want 00 01", out_map[2][3], out_map[2][4]); end
        vec_cnt++; if (pop_cnt !== W*H) begin err_cnt++; $display("FAIL midrst_pops2: got %0d want %0d", pop_cnt, W*H); end
    endtask

    task automatic test_frame_wrap;
        restart_cnt = 0;
        for (int f = 0; f < 254; f++) begin
            cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
            idle(1);
        end
        vec_cnt++; if (o_frame_cnt !== 8'd255) begin err_cnt++; $display("FAIL wrap_255: got %0d want 255", o_frame_cnt); end
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        idle(1);
        vec_cnt++; if (o_frame_cnt !== 8'd0) begin err_cnt++; $display("FAIL wrap_0: got %0d want 0", o_frame_cnt); end
        vec_cnt++; if (restart_cnt !== 255) begin err_cnt++; $display("FAIL wrap_restarts: got %0d want 255", restart_cnt); end
    endtask

    task automatic test_vs_high_reset;
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        rst_n = 1'b1;
        restart_cnt = 0; pop_cnt = 0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, X0, Y0, 1'b1);
        idle(2);
        vec_cnt++; if (restart_cnt !== 0) begin err_cnt++; $display("FAIL vshigh_restart: got %0d want 0", restart_cnt); end
        vec_cnt++; if (pop_cnt !== 0) begin err_cnt++; $display("FAIL vshigh_unarmed_pop: got %0d want 0", pop_cnt); end
        vec_cnt++; if (o_frame_cnt !== 8'd0) begin err_cnt++; $display("FAIL vshigh_frame_cnt: got %0d want 0", o_frame_cnt); end
        run_frame(-1);
        vec_cnt++; if (restart_cnt !== 1 || o_frame_cnt !== 8'd1) begin err_cnt++; $display("FAIL vshigh_next_frame: got restarts %0d cnt %0d want 1 1", restart_cnt, o_frame_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; i_de = 0; i_hs = 0; i_vs = 0; i_valid = 0; i_data = 0;
        i_cnt_hor = 0; i_cnt_ver = 0; i_mode = 2'd0; i_thresh = 8'h00;
        ld_base = 8'h00; ld_ptr = 0; drop_en = 1'b0;
        pop_cnt = 0; restart_cnt = 0; sync_err = 0;
        for (int i = 0; i < 2; i++) begin
            h_de[i] = 1'b0; h_hs[i] = 1'b0; h_vs[i] = 1'b0; h_x[i] = 0; h_y[i] = 0;
        end
        @(negedge sys_clk);
        test_reset;
        test_basic_frame;
        test_window_edges;
        test_underflow;
        test_modes;
        test_mid_reset;
        test_frame_wrap;
        test_vs_high_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
